// File: rtl/instruction_cache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
// The field positions describe how a byte PC splits into word, index and tag.
package instruction_cache_pkg;
  localparam int INDEX_BITS = 3;
  localparam int TAG_BITS   = 3;
  localparam int WORDS      = 4;
  localparam int WORD_LSB   = 2;
  localparam int INDEX_LSB  = 4;
  localparam int TAG_LSB    = 7;
  localparam int BLOCK_BITS = WORDS * 32;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int ADDR_BITS  = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;
endpackage

// File: rtl/icache_word_select.sv
// Picks one 32-bit word out of a 128-bit cache block by word offset.
module icache_word_select
  import instruction_cache_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] block,
  input  logic [1:0]            offset,
  output logic [31:0]           word
);
  assign word = block[{offset, 5'b00000} +: 32];
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit lookup, and a
// three-state refill FSM (IDLE -> MEM_READ -> UPDATE) on a miss.
module instruction_cache
  import instruction_cache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_BITS-1:0]  MEM_ADDRESS,
  input  logic [BLOCK_BITS-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic [1:0]            dbg_state
);
  // Handshake: BUSYWAIT=1 tells the cpu to hold PC; INSTRUCTION is valid only
  // while BUSYWAIT=0. Memory data is taken on the edge where MEM_BUSYWAIT=0
  // while MEM_READ=1; MEM_BUSYWAIT is ignored when MEM_READ=0.
  state_t state, state_next;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [BLOCK_BITS-1:0] data_mem [LINES];
  logic [ADDR_BITS-1:0]  miss_addr;
  logic [BLOCK_BITS-1:0] fill_buf;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  busy_raw;
  logic                  unused_pc;

  assign idx       = PC[INDEX_LSB +: INDEX_BITS];
  assign tag       = PC[TAG_LSB +: TAG_BITS];
  assign unused_pc = ^{PC[31:TAG_LSB+TAG_BITS], PC[WORD_LSB-1:0]};
  assign hit       = valid[idx] && (tag_mem[idx] == tag);

  icache_word_select u_word_select (
    .block  (data_mem[idx]),
    .offset (PC[WORD_LSB +: 2]),
    .word   (INSTRUCTION)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:     state_next = hit ? S_IDLE : S_MEM_READ;
      S_MEM_READ: state_next = MEM_BUSYWAIT ? S_MEM_READ : S_UPDATE;
      S_UPDATE:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    MEM_READ = 1'b0;
    busy_raw = 1'b0;
    case (state)
      S_IDLE:     busy_raw = ~hit;
      S_MEM_READ: begin
        MEM_READ = 1'b1;
        busy_raw = 1'b1;
      end
      S_UPDATE:   busy_raw = 1'b1;
      default:    busy_raw = ~hit;
    endcase
  end

  // Gated by reset so the cpu sees no stall while the cache is held in reset.
  assign BUSYWAIT    = RESET & busy_raw;
  assign MEM_ADDRESS = miss_addr;
  assign dbg_state   = state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid     <= '0;
      miss_addr <= '0;
      fill_buf  <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (!hit) miss_addr <= {tag, idx};
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
        end
        S_UPDATE: begin
          data_mem[miss_addr[INDEX_BITS-1:0]] <= fill_buf;
          tag_mem[miss_addr[INDEX_BITS-1:0]]  <= miss_addr[ADDR_BITS-1:INDEX_BITS];
          valid[miss_addr[INDEX_BITS-1:0]]    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
